// File: rtl/seed_random_mc_ctrl.sv
// ----------------------------------------------------------------------------
// seed_random_mc_ctrl
//   Multi-channel card-rank generator. Arbitrates round-robin among N_CH
//   level requests, draws a rank 1..CARD_MAX from a free-running Galois LFSR
//   by rejection sampling (with a deterministic fallback after MAX_TRIES
//   attempts), and returns the rank plus the owning channel over a
//   valid/ack handshake.
//
// Ports
//   clk_cp_i      clock
//   rst_cp_i      asynchronous active-low reset
//   req_card_i    [N_CH]   per-channel request (level)
//   card_ack_i    consumer accepts card_o (only observed in SEND)
//   seed_load_i   (SEED_RANDOM_SEED_LOAD_EN) load seed_i into the LFSR
//   seed_i        [LFSR_W] (SEED_RANDOM_SEED_LOAD_EN) seed value, 0 -> SEED
//   card_o        [CARD_W] drawn rank
//   card_ch_o     [CH_W]   channel owning card_o
//   card_valid_o  card_o/card_ch_o valid
//   busy_o        high in GEN or SEND
//   state_o       [2]      IDLE=0, GEN=1, SEND=2
//
// Optional feature macro: SEED_RANDOM_SEED_LOAD_EN (runtime seed load).
// ----------------------------------------------------------------------------
module seed_random_mc_ctrl #(
    parameter int                N_CH      = 4,
    parameter int                CH_W      = 2,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                CARD_W    = 4,
    parameter int                CARD_MAX  = 13,
    parameter int                MAX_TRIES = 8
) (
    input  logic              clk_cp_i,
    input  logic              rst_cp_i,
    input  logic [N_CH-1:0]   req_card_i,
    input  logic              card_ack_i,
`ifdef SEED_RANDOM_SEED_LOAD_EN
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_i,
`endif
    output logic [CARD_W-1:0] card_o,
    output logic [CH_W-1:0]   card_ch_o,
    output logic              card_valid_o,
    output logic              busy_o,
    output logic [1:0]        state_o
);

    localparam logic [LFSR_W-1:0] POLY  = LFSR_W'(16'hB400);
    localparam int                TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [LFSR_W-1:0] r_lfsr,  w_lfsr_nxt, w_lfsr_step;
    logic [CARD_W-1:0] r_card,  w_card_nxt;
    logic [CH_W-1:0]   r_ch,    w_ch_nxt;
    logic [CH_W-1:0]   r_last,  w_last_nxt;
    logic [TRY_W-1:0]  r_tries, w_tries_nxt;
    logic              r_valid, w_valid_nxt;

    logic [CARD_W-1:0] w_sample;
    logic              w_legal;
    logic [CARD_W-1:0] w_fallback;

    logic              w_gnt_found;
    logic [CH_W-1:0]   w_gnt_idx;
    int                w_best;
    int                w_dist;

    // ------------------------------------------------------------------
    // LFSR: steps every cycle regardless of FSM state
    // ------------------------------------------------------------------
    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ POLY) : (r_lfsr >> 1);

`ifdef SEED_RANDOM_SEED_LOAD_EN
    // A zero seed would lock the LFSR, so it is replaced by SEED.
    assign w_lfsr_nxt = seed_load_i ? ((seed_i == '0) ? SEED : seed_i) : w_lfsr_step;
`else
    assign w_lfsr_nxt = w_lfsr_step;
`endif

    // ------------------------------------------------------------------
    // Rejection sampling on the low CARD_W bits of the current LFSR value
    // ------------------------------------------------------------------
    assign w_sample   = r_lfsr[CARD_W-1:0];
    assign w_legal    = (w_sample != '0) && (w_sample <= CARD_W'(CARD_MAX));
    // Fold an illegal sample back into range: 0 -> CARD_MAX, >MAX -> s-MAX.
    assign w_fallback = (w_sample == '0) ? CARD_W'(CARD_MAX)
                                         : (w_sample - CARD_W'(CARD_MAX));

    // ------------------------------------------------------------------
    // Round-robin arbiter: the lowest rotated distance from last_grant+1 wins
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_best      = N_CH;
        w_dist      = 0;
        for (int i = 0; i < N_CH; i++) begin
            w_dist = (i + N_CH - 1 - int'(r_last)) % N_CH;
            if (req_card_i[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_gnt_found = 1'b1;
                w_gnt_idx   = CH_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_cp_i or negedge rst_cp_i) begin
        if (!rst_cp_i) begin
            r_state <= ST_IDLE;
            r_lfsr  <= SEED;
            r_card  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_last  <= CH_W'(N_CH - 1);
            r_tries <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_card  <= w_card_nxt;
            r_ch    <= w_ch_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_tries <= w_tries_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-data logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_card_nxt  = r_card;
        w_ch_nxt    = r_ch;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_tries_nxt = r_tries;

        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt_found) begin
                    w_ch_nxt    = w_gnt_idx;
                    w_tries_nxt = '0;
                    w_state_nxt = ST_GEN;
                end
            end
            ST_GEN: begin
                if (w_legal) begin
                    w_card_nxt  = w_sample;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_SEND;
                end else if (r_tries == TRY_W'(MAX_TRIES - 1)) begin
                    w_card_nxt  = w_fallback;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_SEND;
                end else begin
                    w_tries_nxt = r_tries + 1'b1;
                end
            end
            ST_SEND: begin
                // card_o/card_ch_o hold until the consumer takes them
                if (card_ack_i) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = r_ch;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign card_o       = r_card;
    assign card_ch_o    = r_ch;
    assign card_valid_o = r_valid;
    assign busy_o       = (r_state != ST_IDLE);
    assign state_o      = r_state;

endmodule

// File: tb/tb_seed_random_mc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seed_random_mc_ctrl
//   Directed + randomized bench. A second instance with MAX_TRIES=1 shares
//   all inputs so the fallback mapping is exercised often; both instances see
//   the same LFSR sequence and grant order, so one reference model covers both.
// ----------------------------------------------------------------------------
module tb_seed_random_mc_ctrl;

    localparam int N_CH      = 4;
    localparam int CARD_MAX  = 13;
    localparam int MAX_TRIES = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic        ack = 1'b0;
    logic [15:0] seed = '0;
    logic        seed_load = 1'b0;

    logic [3:0]  card,  card1;
    logic [1:0]  ch,    ch1;
    logic        valid, valid1;
    logic        busy,  busy1;
    logic [1:0]  st,    st1;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    int          m_last = N_CH - 1;

    seed_random_mc_ctrl #(.MAX_TRIES(MAX_TRIES)) u_dut (
        .clk_cp_i(clk), .rst_cp_i(rst_n), .req_card_i(req), .card_ack_i(ack),
`ifdef SEED_RANDOM_SEED_LOAD_EN
        .seed_load_i(seed_load), .seed_i(seed),
`endif
        .card_o(card), .card_ch_o(ch), .card_valid_o(valid),
        .busy_o(busy), .state_o(st)
    );

    seed_random_mc_ctrl #(.MAX_TRIES(1)) u_dut1 (
        .clk_cp_i(clk), .rst_cp_i(rst_n), .req_card_i(req), .card_ack_i(ack),
`ifdef SEED_RANDOM_SEED_LOAD_EN
        .seed_load_i(seed_load), .seed_i(seed),
`endif
        .card_o(card1), .card_ch_o(ch1), .card_valid_o(valid1),
        .busy_o(busy1), .state_o(st1)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic bit legal(input int s);
        return (s >= 1) && (s <= CARD_MAX);
    endfunction

    function automatic int fold(input int s);
        return (s == 0) ? CARD_MAX : s - CARD_MAX;
    endfunction

    // Reference LFSR, tracked from reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_lfsr <= 16'hACE1;
`ifdef SEED_RANDOM_SEED_LOAD_EN
        else if (seed_load)
            m_lfsr <= (seed == 16'h0) ? 16'hACE1 : seed;
`endif
        else
            m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_card"},  card,  0);
        chk({tag, "_ch"},    ch,    0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"},  busy,  0);
        chk({tag, "_state"}, st,    0);
        chk({tag, "_valid1"}, valid1, 0);
        chk({tag, "_state1"}, st1,    0);
    endtask

    // One full transaction, entered and left at a negedge with the DUT in IDLE.
    task automatic txn(input logic [3:0] r, input int ack_dly, input bit do_load,
                       input logic [15:0] sv, output int got_ch, output int got_card);
        logic [15:0] v;
        int exp_ch, gen, exp_card, exp_card1, s;
        chk("pre_idle", st, 0);
        exp_ch = -1;
        for (int k = 1; k <= N_CH; k++)
            if (exp_ch < 0 && r[(m_last + k) % N_CH]) exp_ch = (m_last + k) % N_CH;
        // LFSR value seen in the first GEN cycle
        v = do_load ? ((sv == 16'h0) ? 16'hACE1 : sv) : lfsr_next(m_lfsr);
        s = int'(v[3:0]);
        exp_card1 = legal(s) ? s : fold(s);
        gen = 0;
        exp_card = 0;
        for (int k = 0; k < MAX_TRIES; k++) begin
            if (k > 0) v = lfsr_next(v);
            s = int'(v[3:0]);
            gen = k + 1;
            if (legal(s)) begin exp_card = s; break; end
            if (k == MAX_TRIES - 1) exp_card = fold(s);
        end
        req = r;
        seed_load = do_load;
        seed = sv;
        @(negedge clk);
        seed_load = 1'b0;
        req = 4'($urandom);            // dropped/changed requests must not matter
        chk("gen_state", st, 1);
        chk("gen_busy", busy, 1);
        chk("gen_valid", valid, 0);
        for (int k = 1; k < gen; k++) begin
            @(negedge clk);
            chk("gen_wait_valid", valid, 0);
        end
        @(negedge clk);
        chk("send_valid", valid, 1);
        chk("send_card", card, exp_card);
        chk("send_ch", ch, exp_ch);
        chk("send_state", st, 2);
        chk("fb_valid", valid1, 1);
        chk("fb_card", card1, exp_card1);
        chk("fb_ch", ch1, exp_ch);
        got_ch = int'(ch);
        got_card = int'(card);
        for (int k = 0; k < ack_dly; k++) begin
            req = 4'($urandom);
`ifdef SEED_RANDOM_SEED_LOAD_EN
            seed_load = 1'($urandom);
            seed = 16'($urandom);
`endif
            @(negedge clk);
            seed_load = 1'b0;
            chk("hold_card", card, exp_card);
            chk("hold_ch", ch, exp_ch);
            chk("hold_valid", valid, 1);
            chk("hold_busy", busy, 1);
            chk("hold_state", st, 2);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        req = '0;
        chk("post_valid", valid, 0);
        chk("post_state", st, 0);
        chk("post_valid1", valid1, 0);
        m_last = exp_ch;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        ack = 1'b0;
        seed_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_last = N_CH - 1;
    endtask

    initial begin
        int gch, gcard, n;
        int rr_exp[5] = '{0, 1, 3, 0, 1};

        // ---- reset state
        #1;
        chk_reset_outputs("rst");
        do_reset();
        chk_reset_outputs("rst_rel");

        // ---- first draw straight from SEED, channel 0 wins after reset
        txn(4'b1111, 0, 1'b0, 16'h0, gch, gcard);
        chk("first_grant", gch, 0);

        // ---- round-robin with a held pattern
        do_reset();
        for (int i = 0; i < 5; i++) begin
            txn(4'b1011, 0, 1'b0, 16'h0, gch, gcard);
            chk("rr_order", gch, rr_exp[i]);
        end

        // ---- ack while idle is ignored
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("idle_ack_state", st, 0);
        chk("idle_ack_valid", valid, 0);

        // ---- long hold in SEND
        txn(4'b0100, 10, 1'b0, 16'h0, gch, gcard);

`ifdef SEED_RANDOM_SEED_LOAD_EN
        // ---- directed seed-load draws
        do_reset();
        txn(4'b0001, 0, 1'b1, 16'h1235, gch, gcard);
        chk("seed_card", gcard, 5);
        chk("seed_ch", gch, 0);
        txn(4'b0100, 0, 1'b1, 16'h000F, gch, gcard);
        chk("reject_card", gcard, 7);
        chk("reject_ch", gch, 2);
        txn(4'b0010, 0, 1'b1, 16'hFFFE, gch, gcard);
        txn(4'b0010, 0, 1'b1, 16'h0010, gch, gcard);
        txn(4'b1000, 0, 1'b1, 16'h0000, gch, gcard);
`endif

        // ---- reset in GEN
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        chk("mid_gen_state", st, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_gen");
        @(negedge clk);
        rst_n = 1'b1;
        m_last = N_CH - 1;
        txn(4'b1111, 0, 1'b0, 16'h0, gch, gcard);
        chk("rst_gen_grant", gch, 0);

        // ---- reset in SEND
        req = 4'b0010;
        n = 0;
        @(negedge clk);
        req = '0;
        while (!valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("send_reached", valid, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_send");
        @(negedge clk);
        rst_n = 1'b1;
        m_last = N_CH - 1;
        txn(4'b1110, 0, 1'b0, 16'h0, gch, gcard);
        chk("rst_send_grant", gch, 1);

        // ---- randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit ld;
            ld = 1'b0;
`ifdef SEED_RANDOM_SEED_LOAD_EN
            ld = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("gap_idle", st, 0);
            end
            txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), ld,
                ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom), gch, gcard);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seed_random_mc_ctrl.md
Name: seed_random_mc_ctrl

Overview:
- Parametrised multi-channel successor of the single-requester card-seed control path.
- Accepts card requests from N_CH players/dealer, arbitrates round-robin, draws a uniformly distributed card rank from a free-running LFSR using rejection sampling, and returns it with channel tag over a valid/ack handshake.
- Sits between the game FSM request lines and the deck/hand datapath.

Parameters:
- N_CH, 4: number of requesting channels (>=1).
- CH_W, 2: channel tag width; must equal max(1, clog2(N_CH)).
- LFSR_W, 16: LFSR width; fixed Galois polynomial mask 16'hB400 (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- CARD_W, 4: card rank width.
- CARD_MAX, 13: highest legal rank; legal ranks are 1..CARD_MAX, with CARD_MAX < 2^CARD_W.
- MAX_TRIES, 8: rejection attempts before fallback mapping.

Ports:
- clk_cp_i  in  1  clock.
- rst_cp_i  in  1  reset, asynchronous, active-low.
- req_card_i  in  N_CH  per-channel card request, level.
- card_ack_i  in  1  consumer accepts card.
- card_o  out  CARD_W  drawn rank.
- card_ch_o  out  CH_W  channel that owns card_o.
- card_valid_o  out  1  card_o/card_ch_o valid.
- busy_o  out  1  high in GEN or SEND.
- state_o  out  2  FSM state: IDLE=0, GEN=1, SEND=2.
- seed_load_i  in  1  (SEED_LOAD_EN only) load seed.
- seed_i  in  LFSR_W  (SEED_LOAD_EN only) seed value.

Behaviour:
- Reset values: lfsr=SEED, state=IDLE, card_o=0, card_ch_o=0, card_valid_o=0, busy_o=0, last_grant=N_CH-1, tries=0.
- LFSR:
  - Steps every cycle in all states.
  - Step rule: lsb=1 -> (lfsr>>1)^16'hB400; lsb=0 -> lfsr>>1.
  - Sample = lfsr[CARD_W-1:0] as registered during the current cycle.
- IDLE:
  - If any req_card_i bit is set, grant the first set bit searching from last_grant+1 upward, wrapping modulo N_CH.
  - Latch grant into card_ch_o; tries=0; go to GEN.
  - No requests: stay in IDLE.
- GEN:
  - Sample in 1..CARD_MAX: card_o=sample; go to SEND.
  - Otherwise tries++ and stay in GEN.
  - If tries==MAX_TRIES-1 and the sample is still illegal, apply the fallback mapping and go to SEND:
    - sample==0 -> card_o=CARD_MAX.
    - sample>CARD_MAX -> card_o=sample-CARD_MAX.
  - GEN therefore lasts at most MAX_TRIES cycles.
- SEND:
  - card_valid_o=1; card_o and card_ch_o held stable until card_ack_i.
  - On ack edge: card_valid_o=0, last_grant=card_ch_o, go to IDLE.
- Latency:
  - Request in IDLE cycle t -> earliest card_valid_o high in cycle t+2.
  - Ack in the first valid cycle completes the transfer at that edge.
  - At least one IDLE cycle between transfers.
- Request changes:
  - A request dropped after grant is ignored; the transaction completes.
  - Requests arriving in GEN/SEND wait for IDLE.
- card_ack_i outside SEND is ignored.
- Async reset mid-GEN or mid-SEND: immediately returns all outputs to reset values; the pending card is discarded.
- busy_o = (state != IDLE); state_o mirrors the state register.

Optional Feature:
- Macro: SEED_RANDOM_SEED_LOAD_EN.
- Defined:
  - seed_load_i and seed_i exist.
  - When seed_load_i=1, lfsr loads seed_i at that edge instead of stepping, in any state.
  - seed_i==0 loads SEED instead, so the LFSR never locks up.
- Undefined: both ports absent; lfsr only resets to SEED and steps.

Test Plan:
- Seed-load draw: SEED_LOAD_EN defined; in IDLE drive seed_load_i=1, seed_i=16'h1235, req_card_i=4'b0001 -> GEN sample 5; card_o=5, card_ch_o=0, card_valid_o=1 two edges later; ack -> IDLE.
- Rejection: load seed 16'h000F with request on channel 2 -> first sample 15 rejected; next lfsr 16'hB407 -> card_o=7, card_ch_o=2, valid on the third edge after the request.
- Round-robin: hold req_card_i=4'b1011 and ack each card immediately -> grants 0,1,3,0,1 in that order; channel 2 is never granted.
- Hold: withhold card_ack_i for 10 cycles in SEND, toggling requests and seed_load_i -> card_o and card_ch_o unchanged, valid stays 1, busy_o=1, state_o=2.
- Fallback: MAX_TRIES=1, load seed 16'h0000 then 16'hFFFE so the sample is 14 -> card_o=1 after a single GEN cycle; a sample of 0 -> card_o=13.
- Reset: assert rst_cp_i low during GEN and during SEND -> outputs return to zero immediately, state_o=0, lfsr=16'hACE1; after release the next request is granted from channel 0.
